// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic {
        RUN           = 1'b0,
        WAIT_REDIRECT = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

    // Observation bundle; queue_count is wide enough for the largest supported depth (8).
    typedef struct packed {
        fetch_state_t state;
        logic         queue_full;
        logic [3:0]   queue_count;
    } fetch_debug_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small prefetch FIFO of {pc, instr} entries with registered head outputs.
module fetch_queue #(
    parameter  int unsigned QUEUE_DEPTH = 2,
    localparam int unsigned PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1,
    localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [31:0]      i_push_pc,
    input  logic [31:0]      i_push_instr,
    output logic [31:0]      o_head_pc,
    output logic [31:0]      o_head_instr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [31:0]      r_pc_mem    [QUEUE_DEPTH];
    logic [31:0]      r_instr_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_pc_mem[r_wr_ptr]    <= i_push_pc;
                r_instr_mem[r_wr_ptr] <= i_push_instr;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_full       = (r_count == CNT_W'(QUEUE_DEPTH));
    assign o_empty      = (r_count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, holds the MMU address until success, and queues fetched words for decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  instructionMemoryAddress,
    input  logic [31:0]  instructionMemoryData,
    input  logic         instructionMemorySuccess,
    input  logic         redirectEnable,
    input  logic [31:0]  redirectPc,
    output logic         fetchValid,
    output logic [31:0]  fetchInstruction,
    output logic [31:0]  fetchPc,
    input  logic         decodeReady,
    output fetch_debug_t o_debug
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [31:0]  r_request_pc;
    logic [31:0]  w_next_request_pc;
    logic [31:0]  r_pending_pc;
    logic [31:0]  w_next_pending_pc;
    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic [CNT_W-1:0] w_count;
    logic         w_full;
    logic         w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_request_pc <= RESET_PC;
            r_pending_pc <= '0;
        end else begin
            r_state      <= w_next_state;
            r_request_pc <= w_next_request_pc;
            r_pending_pc <= w_next_pending_pc;
        end
    end

    // A redirect flushes the queue, so the head is never consumed in that cycle.
    always_comb begin
        w_next_state      = r_state;
        w_next_request_pc = r_request_pc;
        w_next_pending_pc = r_pending_pc;
        w_push            = 1'b0;
        w_flush           = 1'b0;
        w_pop             = fetchValid & decodeReady & ~redirectEnable;
        case (r_state)
            RUN: begin
                if (redirectEnable) begin
                    w_flush = 1'b1;
                    if (instructionMemorySuccess) begin
                        w_next_request_pc = align_pc(redirectPc);
                    end else begin
                        w_next_pending_pc = align_pc(redirectPc);
                        w_next_state      = WAIT_REDIRECT;
                    end
                end else if (instructionMemorySuccess &&
                             ((w_count < CNT_W'(QUEUE_DEPTH)) || w_pop)) begin
                    w_push            = 1'b1;
                    w_next_request_pc = r_request_pc + 32'(INSTR_BYTES);
                end
            end
            WAIT_REDIRECT: begin
                w_flush = redirectEnable;
                // The address must not move until the miss in flight completes.
                if (instructionMemorySuccess) begin
                    w_next_request_pc = redirectEnable ? align_pc(redirectPc) : r_pending_pc;
                    w_next_state      = RUN;
                end else if (redirectEnable) begin
                    w_next_pending_pc = align_pc(redirectPc);
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_push_pc    (r_request_pc),
        .i_push_instr (instructionMemoryData),
        .o_head_pc    (fetchPc),
        .o_head_instr (fetchInstruction),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign instructionMemoryAddress = r_request_pc;
    assign fetchValid               = ~w_empty;

    assign o_debug.state       = r_state;
    assign o_debug.queue_full  = w_full;
    assign o_debug.queue_count = 4'(w_count);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Table-driven bench for instruction_fetch_unit with a scoreboard of delivered {pc, instr} entries.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  instructionMemoryAddress;
    logic [31:0]  instructionMemoryData = '0;
    logic         instructionMemorySuccess = 1'b0;
    logic         redirectEnable = 1'b0;
    logic [31:0]  redirectPc = '0;
    logic         fetchValid;
    logic [31:0]  fetchInstruction;
    logic [31:0]  fetchPc;
    logic         decodeReady = 1'b0;
    fetch_debug_t dbg;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .instructionMemoryAddress (instructionMemoryAddress),
        .instructionMemoryData    (instructionMemoryData),
        .instructionMemorySuccess (instructionMemorySuccess),
        .redirectEnable           (redirectEnable),
        .redirectPc               (redirectPc),
        .fetchValid               (fetchValid),
        .fetchInstruction         (fetchInstruction),
        .fetchPc                  (fetchPc),
        .decodeReady              (decodeReady),
        .o_debug                  (dbg)
    );

    typedef struct {
        logic        first;
        logic        succ;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_wait;
        logic        exp_push;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          idx_b;
    int          idx_d;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_C3C3;
    endfunction

    task automatic add(input int first, input int succ, input int redir, input logic [31:0] rpc,
                       input int ready, input logic [31:0] addr, input int valid,
                       input logic [31:0] pc, input int wait_st, input int push);
        vec_t v;
        v.first     = (first != 0);
        v.succ      = (succ != 0);
        v.redir     = (redir != 0);
        v.rpc       = rpc;
        v.ready     = (ready != 0);
        v.exp_addr  = addr;
        v.exp_valid = (valid != 0);
        v.exp_pc    = pc;
        v.exp_wait  = (wait_st != 0);
        v.exp_push  = (push != 0);
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        instructionMemorySuccess = 1'b0;
        instructionMemoryData    = '0;
        redirectEnable           = 1'b0;
        redirectPc               = '0;
        decodeReady              = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check32("reset_addr", instructionMemoryAddress, 32'h0000_0000);
        check32("reset_valid", 32'(fetchValid), 32'd0);
        check32("reset_instr", fetchInstruction, 32'd0);
        check32("reset_pc", fetchPc, 32'd0);
        check32("reset_state", 32'(dbg.state), 32'(RUN));
        reset = 1'b1;
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        logic [63:0] e;
        @(negedge clk);
        check32($sformatf("addr[%0d]", idx), instructionMemoryAddress, v.exp_addr);
        check32($sformatf("valid[%0d]", idx), 32'(fetchValid), 32'(v.exp_valid));
        check32($sformatf("wait_state[%0d]", idx), 32'(dbg.state == WAIT_REDIRECT), 32'(v.exp_wait));
        if (v.exp_valid) begin
            check32($sformatf("head_pc[%0d]", idx), fetchPc, v.exp_pc);
        end
        if (fetchValid && v.ready && !v.redir) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver[%0d]: got pc %h expected no delivery", idx, fetchPc);
            end else begin
                e = exp_q.pop_front();
                check32($sformatf("deliver_pc[%0d]", idx), fetchPc, e[63:32]);
                check32($sformatf("deliver_instr[%0d]", idx), fetchInstruction, e[31:0]);
            end
        end
        if (v.redir) exp_q.delete();
        if (v.exp_push) exp_q.push_back({v.exp_addr, instr_of(v.exp_addr)});
        instructionMemorySuccess = v.succ;
        instructionMemoryData    = v.succ ? instr_of(instructionMemoryAddress) : 32'hDEAD_0000;
        redirectEnable           = v.redir;
        redirectPc               = v.rpc;
        decodeReady              = v.ready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // first succ redir rpc ready | addr valid pc wait push
        // Always hit, decode ready: streaming 0,4,8
        add(1, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h8, 1, 32'h4, 0, 1);
        add(0, 1, 0, 0, 1, 32'hC, 1, 32'h8, 0, 1);
        // Decode stalled: two entries, address held at 8, then release
        idx_b = vecs.size();
        add(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 0, 32'h4, 1, 32'h0, 0, 1);
        add(0, 1, 0, 0, 0, 32'h8, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 0, 32'h8, 1, 32'h0, 0, 0);
        add(0, 1, 0, 0, 1, 32'h8, 1, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'hC, 1, 32'h4, 0, 1);
        add(0, 1, 0, 0, 1, 32'h10, 1, 32'h8, 0, 1);
        // 3-cycle miss at 0x10
        add(1, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h8, 1, 32'h4, 0, 1);
        add(0, 1, 0, 0, 1, 32'hC, 1, 32'h8, 0, 1);
        add(0, 0, 0, 0, 1, 32'h10, 1, 32'hC, 0, 0);
        add(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h10, 0, 32'h0, 0, 0);
        add(0, 1, 0, 0, 1, 32'h10, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h14, 1, 32'h10, 0, 1);
        // Redirect on hit to 0x20, then redirect to 0x103 during the miss at 0x20
        idx_d = vecs.size();
        add(1, 1, 1, 32'h20, 1, 32'h0, 0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h20, 0, 32'h0, 0, 0);
        add(0, 0, 1, 32'h103, 1, 32'h20, 0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 1, 32'h20, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 1, 32'h20, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 1, 32'h100, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h104, 1, 32'h100, 0, 1);
        add(0, 1, 0, 0, 1, 32'h108, 1, 32'h104, 0, 1);
        // Second redirect in WAIT_REDIRECT overwrites the pending target
        add(1, 0, 1, 32'h200, 1, 32'h0, 0, 32'h0, 0, 0);
        add(0, 0, 1, 32'h301, 1, 32'h0, 0, 32'h0, 1, 0);
        add(0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 1, 32'h0, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 1, 32'h300, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h304, 1, 32'h300, 0, 1);
        // Redirect coinciding with success in WAIT_REDIRECT loads directly
        add(1, 0, 1, 32'h500, 1, 32'h0, 0, 32'h0, 0, 0);
        add(0, 1, 1, 32'h602, 1, 32'h0, 0, 32'h0, 1, 0);
        add(0, 1, 0, 0, 1, 32'h600, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h604, 1, 32'h600, 0, 1);
        // Redirect to 0x40 with a hit and a pop: flush beats pop
        add(1, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0, 1);
        add(0, 1, 1, 32'h40, 1, 32'h8, 1, 32'h4, 0, 0);
        add(0, 1, 0, 0, 1, 32'h40, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h44, 1, 32'h40, 0, 1);
        // PC wraps modulo 2^32
        add(1, 1, 1, 32'hFFFF_FFFC, 1, 32'h0, 0, 32'h0, 0, 0);
        add(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC, 0, 1);
        add(0, 1, 0, 0, 1, 32'h4, 1, 32'h0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].first) do_reset();
            apply_row(vecs[i], i);
        end

        // Reset asserted mid-miss with a full queue
        do_reset();
        for (int i = idx_b; i < idx_b + 4; i++) apply_row(vecs[i], i);
        @(negedge clk);
        check32("pre_reset_miss_addr", instructionMemoryAddress, 32'h8);
        check32("pre_reset_miss_valid", 32'(fetchValid), 32'd1);
        instructionMemorySuccess = 1'b0;
        #2 reset = 1'b0;
        #1;
        check32("reset_miss_addr", instructionMemoryAddress, 32'h0);
        check32("reset_miss_valid", 32'(fetchValid), 32'd0);
        check32("reset_miss_pc", fetchPc, 32'd0);
        check32("reset_miss_instr", fetchInstruction, 32'd0);

        // Reset asserted while waiting on a redirect
        do_reset();
        for (int i = idx_d; i < idx_d + 4; i++) apply_row(vecs[i], i);
        @(negedge clk);
        check32("pre_reset_wait_state", 32'(dbg.state), 32'(WAIT_REDIRECT));
        instructionMemorySuccess = 1'b0;
        redirectEnable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check32("reset_wait_state", 32'(dbg.state), 32'(RUN));
        check32("reset_wait_addr", instructionMemoryAddress, 32'h0);
        check32("reset_wait_valid", 32'(fetchValid), 32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage sitting directly upstream of the MMU instruction port. Owns the program counter, drives `instructionMemoryAddress`, and holds it stable until `instructionMemorySuccess`, including across L1 misses. Fetched words are buffered with their PC in a small prefetch queue for decode. Branch/jump redirects flush the queue without ever changing the address under an outstanding miss.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `QUEUE_DEPTH`, 2, prefetch entries; power of two, 2..8.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `instructionMemoryAddress` out 32: fetch address to MMU; always equals internal `requestPc`.
- `instructionMemoryData` in 32: MMU `instructionMemoryDataOut`; valid only when success = 1.
- `instructionMemorySuccess` in 1: MMU hit/peripheral-ready, combinational in the same cycle.
- `redirectEnable` in 1: one-cycle pulse from execute; a taken branch/jump.
- `redirectPc` in 32: target; bits [1:0] forced to 0.
- `fetchValid` out 1: queue head valid.
- `fetchInstruction` out 32: head instruction.
- `fetchPc` out 32: head PC.
- `decodeReady` in 1: decode consumes head when `fetchValid & decodeReady`.

## Operation
- States: RUN, WAIT_REDIRECT.
- RUN, no redirect:
  - `push = success & (count < QUEUE_DEPTH | pop)`.
  - On push, write {requestPc, data} and set `requestPc += 4`, wrapping modulo 2^32.
  - When the queue is full and there is no pop, hold the address and ignore success.
- RUN, redirect with success = 1: discard the data, flush the queue, `requestPc <= redirectPc & ~3`, stay in RUN.
- RUN, redirect with success = 0 (miss in flight): flush the queue, latch `pendingPc <= redirectPc & ~3`, go to WAIT_REDIRECT, keep the address unchanged.
- WAIT_REDIRECT:
  - Push is never allowed.
  - On success, discard the data, `requestPc <= pendingPc`, go to RUN.
  - A further redirect overwrites `pendingPc`.
  - A redirect arriving in the same cycle as success is loaded directly into `requestPc`.
- Flush beats pop: on a redirect cycle the head is not counted as consumed, and `fetchValid` = 0 on the next cycle.
- Address bit 31 (peripheral space) needs no special handling.

## Timing
- Reset values: `requestPc = RESET_PC`, queue empty, `fetchValid = 0`, `fetchInstruction = 0`, `fetchPc = 0`, state RUN, `pendingPc = 0`.
- Hit path: address in cycle N, success in N, entry written at the end of N, `fetchValid` = 1 in N+1. Steady-state throughput is one instruction per cycle.
- Miss: the address is held for all k cycles until success.
- Queue outputs are registered; the head is stable while `fetchValid & ~decodeReady`.
- Simultaneous push and pop on a full queue: both happen, count unchanged.
- Reset asserted mid-miss or mid-WAIT_REDIRECT: immediate return to reset values. The MMU sees `RESET_PC` asynchronously.

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t` {RUN, WAIT_REDIRECT}; `INSTR_BYTES = 4`; `ALIGN_MASK = 32'hFFFF_FFFC`.
- Sub-module `fetch_queue`:
  - Parameterised FIFO of {pc, instr} entries.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Pointers are log2(QUEUE_DEPTH) bits with a separate count.
- Top level: FSM, `requestPc`/`pendingPc` registers, push/pop logic.

## Test plan
- Reset, `RESET_PC` = 0, always-hit MMU, `decodeReady` = 1 -> address 0,4,8,…; `fetchPc` 0,4,8 on consecutive cycles from cycle 1.
- `decodeReady` = 0 with hits -> exactly 2 entries (0,4), address held at 8. Release -> 0,4,8 delivered in order, none lost or duplicated.
- 3-cycle miss at 0x10 -> address stays 0x10 for 3 cycles; entry 0x10 appears the cycle after success.
- Redirect to 0x103 during a miss at 0x20 -> address stays 0x20 until success, data discarded, then address 0x100. Queue is empty throughout; first delivered PC is 0x100.
- Redirect to 0x40 in a cycle with a hit and a pop -> `fetchValid` = 0 next cycle, next address 0x40, first delivered PC is 0x40.
- `requestPc` = 0xFFFF_FFFC with a hit -> next address 0x0000_0000. Reset pulsed mid-miss -> address returns to `RESET_PC` immediately, `fetchValid` = 0.
